// File: rtl/ct_ebiu_ncwt_pkg.sv
// rtl/ct_ebiu_ncwt_pkg.sv - shared constants, types and age helper for the NCWT scheduler
package ct_ebiu_ncwt_pkg;

  localparam int ENTRY_MAX = 16;
  localparam logic [4:0] WO_EX_ID = 5'b11110;

  typedef logic [$clog2(ENTRY_MAX)-1:0] entry_idx_t;
  typedef logic [ENTRY_MAX-1:0][ENTRY_MAX-1:0] age_mtx_t;

  // The oldest masked entry is the one no other masked entry is older than.
  function automatic entry_idx_t oldest_idx(input age_mtx_t age, input logic [ENTRY_MAX-1:0] mask);
    entry_idx_t idx;
    logic       older;
    idx = '0;
    for (int i = 0; i < ENTRY_MAX; i++) begin
      older = 1'b0;
      for (int j = 0; j < ENTRY_MAX; j++) begin
        if (j != i && mask[j] && age[j][i]) older = 1'b1;
      end
      if (mask[i] && !older) idx = entry_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ct_ebiu_ncwt_sched_if.sv
// rtl/ct_ebiu_ncwt_sched_if.sv - request, completion, response and entry-status bundle of the NCWT scheduler
interface ct_ebiu_ncwt_sched_if #(
  parameter int NUM_ENTRY = 8,
  parameter int IDXW      = $clog2(NUM_ENTRY)
);
  logic                 ncq_aw_create_vld;
  logic [7:0]           ncq_xx_awid;
  logic                 aw_needissue;
  logic                 ncwt_full;
  logic [NUM_ENTRY-1:0] ncwt_create_en;
  logic                 ncq_wdata_done;
  logic [NUM_ENTRY-1:0] ncwt_wdata_create_en;
  logic                 bfifo_pop_vld;
  logic [7:0]           bfifo_pop_bid;
  logic [NUM_ENTRY-1:0] ncwt_bus_bresp_updt_en;
  logic                 bid_miss_err;
  logic [NUM_ENTRY-1:0] ncwt_vld;
  logic [NUM_ENTRY-1:0] ncwt_bvalid;
  logic                 ebiu_b_vld;
  logic [IDXW-1:0]      ebiu_b_sel;
  logic                 piu_b_ready;
  logic [NUM_ENTRY-1:0] ncwt_bresp_accept_en;

  modport master (
    output ncq_aw_create_vld, ncq_xx_awid, aw_needissue, ncq_wdata_done,
           bfifo_pop_vld, bfifo_pop_bid, ncwt_vld, ncwt_bvalid, piu_b_ready,
    input  ncwt_full, ncwt_create_en, ncwt_wdata_create_en, ncwt_bus_bresp_updt_en,
           bid_miss_err, ebiu_b_vld, ebiu_b_sel, ncwt_bresp_accept_en
  );

  modport slave (
    input  ncq_aw_create_vld, ncq_xx_awid, aw_needissue, ncq_wdata_done,
           bfifo_pop_vld, bfifo_pop_bid, ncwt_vld, ncwt_bvalid, piu_b_ready,
    output ncwt_full, ncwt_create_en, ncwt_wdata_create_en, ncwt_bus_bresp_updt_en,
           bid_miss_err, ebiu_b_vld, ebiu_b_sel, ncwt_bresp_accept_en
  );

endinterface

// File: rtl/ct_ebiu_ncwt_rr_arb.sv
// rtl/ct_ebiu_ncwt_rr_arb.sv - round-robin return arbiter: first requester at or after the pointer
module ct_ebiu_ncwt_rr_arb
  import ct_ebiu_ncwt_pkg::*;
#(
  parameter int NUM_ENTRY = 8,
  parameter int IDXW      = $clog2(NUM_ENTRY)
) (
  input  logic [NUM_ENTRY-1:0] req_i,
  input  logic [IDXW-1:0]      ptr_i,
  output logic [IDXW-1:0]      gnt_idx_o
);

  logic [IDXW-1:0] idx;
  logic            found;

  // Index arithmetic wraps in IDXW bits since NUM_ENTRY is a power of two.
  always_comb begin
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    for (int off = 0; off < NUM_ENTRY; off++) begin
      idx = ptr_i + IDXW'(off);
      if (!found && req_i[idx]) begin
        found     = 1'b1;
        gnt_idx_o = idx;
      end
    end
  end

endmodule

// File: rtl/ct_ebiu_ncwt_sched.sv
// rtl/ct_ebiu_ncwt_sched.sv - NCWT scheduler: entry allocation, age-ordered data/response steering,
// and round-robin B return arbitration.
module ct_ebiu_ncwt_sched
  import ct_ebiu_ncwt_pkg::*;
#(
  parameter int NUM_ENTRY = 8
) (
  input logic                 ncwt_ctrl_clk,
  input logic                 cpurst_b,
  ct_ebiu_ncwt_sched_if.slave sif
);

  localparam int IDXW = $clog2(NUM_ENTRY);

  logic [NUM_ENTRY-1:0][NUM_ENTRY-1:0] age_q, age_d;
  logic [NUM_ENTRY-1:0]                wdata_pend_q, wdata_pend_d;
  logic [NUM_ENTRY-1:0]                bus_wait_q, bus_wait_d;
  logic [NUM_ENTRY-1:0]                alloc_pend_q, alloc_pend_d;
  logic [NUM_ENTRY-1:0][7:0]           id_q, id_d;
  logic [IDXW-1:0]                     rr_ptr_q, rr_ptr_d;
  logic                                hold_vld_q, hold_vld_d;
  logic [IDXW-1:0]                     hold_idx_q, hold_idx_d;

  logic [NUM_ENTRY-1:0] free, create_oh, wdata_oh, bus_match, bus_oh, accept_oh;
  age_mtx_t             age_ext;
  entry_idx_t           wdata_old, bus_old;
  logic [IDXW-1:0]      arb_idx, sel;
  logic                 b_vld, accept, is_excl;

  // ncwt_vld lags a create by one cycle, so last cycle's strobe is still taken.
  assign free      = ~sif.ncwt_vld & ~alloc_pend_q;
  assign create_oh = sif.ncq_aw_create_vld ? (free & (~free + NUM_ENTRY'(1))) : '0;
  assign is_excl   = (sif.ncq_xx_awid[4:0] == WO_EX_ID);

  always_comb begin
    age_ext = '0;
    for (int i = 0; i < NUM_ENTRY; i++) age_ext[i][NUM_ENTRY-1:0] = age_q[i];
  end

  always_comb begin
    bus_match = '0;
    for (int i = 0; i < NUM_ENTRY; i++)
      bus_match[i] = bus_wait_q[i] && (id_q[i] == sif.bfifo_pop_bid);
  end

  assign wdata_old = oldest_idx(age_ext, ENTRY_MAX'(wdata_pend_q));
  assign bus_old   = oldest_idx(age_ext, ENTRY_MAX'(bus_match));
  assign wdata_oh  = (sif.ncq_wdata_done && |wdata_pend_q) ? (NUM_ENTRY'(1) << wdata_old) : '0;
  assign bus_oh    = (sif.bfifo_pop_vld && |bus_match) ? (NUM_ENTRY'(1) << bus_old) : '0;

  ct_ebiu_ncwt_rr_arb #(
    .NUM_ENTRY (NUM_ENTRY),
    .IDXW      (IDXW)
  ) u_rr_arb (
    .req_i     (sif.ncwt_bvalid),
    .ptr_i     (rr_ptr_q),
    .gnt_idx_o (arb_idx)
  );

  // An offered but unaccepted entry stays selected while its bvalid holds.
  assign sel       = (hold_vld_q && sif.ncwt_bvalid[hold_idx_q]) ? hold_idx_q : arb_idx;
  assign b_vld     = |sif.ncwt_bvalid;
  assign accept    = b_vld && sif.piu_b_ready;
  assign accept_oh = accept ? (NUM_ENTRY'(1) << sel) : '0;

  assign sif.ncwt_full              = (free == '0);
  assign sif.ncwt_create_en         = create_oh;
  assign sif.ncwt_wdata_create_en   = wdata_oh;
  assign sif.ncwt_bus_bresp_updt_en = bus_oh;
  assign sif.bid_miss_err           = sif.bfifo_pop_vld && !(|bus_match);
  assign sif.ebiu_b_vld             = b_vld;
  assign sif.ebiu_b_sel             = sel;
  assign sif.ncwt_bresp_accept_en   = accept_oh;

  always_comb begin
    age_d        = age_q;
    wdata_pend_d = wdata_pend_q & ~wdata_oh;
    bus_wait_d   = bus_wait_q & ~bus_oh;
    id_d         = id_q;
    for (int k = 0; k < NUM_ENTRY; k++) begin
      if (create_oh[k]) begin
        for (int j = 0; j < NUM_ENTRY; j++) begin
          age_d[k][j] = 1'b0;
          if (j != k) age_d[j][k] = 1'b1;
        end
        wdata_pend_d[k] = 1'b1;
        bus_wait_d[k]   = sif.aw_needissue || !is_excl;
        id_d[k]         = sif.ncq_xx_awid;
      end
    end
    alloc_pend_d = create_oh;
    rr_ptr_d     = accept ? sel + IDXW'(1) : rr_ptr_q;
    hold_vld_d   = b_vld && !sif.piu_b_ready;
    hold_idx_d   = sel;
  end

  always_ff @(posedge ncwt_ctrl_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      age_q        <= '0;
      wdata_pend_q <= '0;
      bus_wait_q   <= '0;
      alloc_pend_q <= '0;
      id_q         <= '0;
      rr_ptr_q     <= '0;
      hold_vld_q   <= 1'b0;
      hold_idx_q   <= '0;
    end else begin
      age_q        <= age_d;
      wdata_pend_q <= wdata_pend_d;
      bus_wait_q   <= bus_wait_d;
      alloc_pend_q <= alloc_pend_d;
      id_q         <= id_d;
      rr_ptr_q     <= rr_ptr_d;
      hold_vld_q   <= hold_vld_d;
      hold_idx_q   <= hold_idx_d;
    end
  end

endmodule

// File: tb/tb_ct_ebiu_ncwt_sched.sv
// tb/tb_ct_ebiu_ncwt_sched.sv - self-checking bench for ct_ebiu_ncwt_sched against a queue-based entry model
module tb_ct_ebiu_ncwt_sched;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  ct_ebiu_ncwt_sched_if #(.NUM_ENTRY(N)) sif ();
  ct_ebiu_ncwt_sched #(.NUM_ENTRY(N)) dut (.ncwt_ctrl_clk(clk), .cpurst_b(rstb), .sif(sif));

  int checks = 0;
  int failures = 0;

  // Model: entry flags, creation-ordered wait lists, stored ids, return pointer.
  logic [N-1:0] m_vld, m_bvalid, m_pend;
  int           q_wd[$];
  int           q_bus[$];
  logic [7:0]   m_id[N];
  int           m_rr, m_hold_idx, e_bus_pos, e_sel;
  logic         m_hold;
  logic [N-1:0] e_create, e_wd, e_bus, e_acc;
  logic         e_full, e_miss, e_bvld;

  task automatic idle_inputs();
    sif.ncq_aw_create_vld = 0; sif.ncq_xx_awid = 0; sif.aw_needissue = 0;
    sif.ncq_wdata_done = 0; sif.bfifo_pop_vld = 0; sif.bfifo_pop_bid = 0; sif.piu_b_ready = 0;
  endtask

  task automatic model_clear();
    m_vld = 0; m_bvalid = 0; m_pend = 0; q_wd.delete(); q_bus.delete();
    for (int i = 0; i < N; i++) m_id[i] = 0;
    m_rr = 0; m_hold = 0; m_hold_idx = 0;
    sif.ncwt_vld = 0; sif.ncwt_bvalid = 0;
  endtask

  task automatic apply_reset();
    idle_inputs(); model_clear(); rstb = 0;
    repeat (2) @(negedge clk);
    rstb = 1;
  endtask

  function automatic bit in_q(input int q[$], input int v);
    foreach (q[i]) if (q[i] == v) return 1;
    return 0;
  endfunction

  // Drive entry flags, derive this cycle's expected outputs, let logic settle.
  task automatic settle();
    logic [N-1:0] free;
    sif.ncwt_vld = m_vld; sif.ncwt_bvalid = m_bvalid;
    free = ~m_vld & ~m_pend;
    e_full = (free == 0);
    e_create = 0;
    if (sif.ncq_aw_create_vld)
      for (int i = 0; i < N; i++) if (free[i]) begin e_create[i] = 1; break; end
    e_wd = (sif.ncq_wdata_done && q_wd.size() > 0) ? (N'(1) << q_wd[0]) : '0;
    e_bus = 0; e_miss = 0; e_bus_pos = -1;
    if (sif.bfifo_pop_vld) begin
      foreach (q_bus[i]) if (m_id[q_bus[i]] == sif.bfifo_pop_bid) begin e_bus_pos = i; break; end
      if (e_bus_pos >= 0) e_bus = N'(1) << q_bus[e_bus_pos];
      else e_miss = 1;
    end
    e_bvld = |m_bvalid;
    e_sel = 0;
    if (m_hold && m_bvalid[m_hold_idx]) e_sel = m_hold_idx;
    else for (int off = 0; off < N; off++)
      if (m_bvalid[(m_rr + off) % N]) begin e_sel = (m_rr + off) % N; break; end
    e_acc = (e_bvld && sif.piu_b_ready) ? (N'(1) << e_sel) : '0;
    #2;
  endtask

  task automatic tick();
    int k;
    @(posedge clk);
    if (|e_wd) void'(q_wd.pop_front());
    if (|e_bus) q_bus.delete(e_bus_pos);
    if (|e_create) begin
      for (int i = 0; i < N; i++) if (e_create[i]) k = i;
      foreach (q_wd[i]) if (q_wd[i] == k) begin q_wd.delete(i); break; end
      foreach (q_bus[i]) if (q_bus[i] == k) begin q_bus.delete(i); break; end
      q_wd.push_back(k);
      m_id[k] = sif.ncq_xx_awid;
      if (sif.aw_needissue || sif.ncq_xx_awid[4:0] != 5'h1E) q_bus.push_back(k);
    end
    if (|e_acc) begin m_rr = (e_sel + 1) % N; m_bvalid[e_sel] = 0; end
    m_hold = e_bvld && !sif.piu_b_ready; m_hold_idx = e_sel;
    m_vld = m_vld | e_create;
    m_pend = e_create;
    @(negedge clk);
  endtask

  task automatic do_create(input logic [7:0] id, input logic ni);
    idle_inputs();
    sif.ncq_aw_create_vld = 1; sif.ncq_xx_awid = id; sif.aw_needissue = ni;
    settle();
    checks++;
    if (sif.ncwt_create_en !== e_create) begin
      failures++; $display("FAIL create_setup: got %h want %h", sif.ncwt_create_en, e_create);
    end
    tick();
  endtask

  task automatic test_reset();
    idle_inputs(); model_clear(); rstb = 0;
    @(negedge clk); #1;
    checks++;
    if ({sif.ncwt_create_en, sif.ncwt_wdata_create_en, sif.ncwt_bus_bresp_updt_en, sif.ncwt_bresp_accept_en} !== '0) begin
      failures++; $display("FAIL reset_strobes: got %h %h %h %h want 0", sif.ncwt_create_en,
        sif.ncwt_wdata_create_en, sif.ncwt_bus_bresp_updt_en, sif.ncwt_bresp_accept_en);
    end
    checks++;
    if ({sif.ncwt_full, sif.bid_miss_err, sif.ebiu_b_vld, sif.ebiu_b_sel} !== '0) begin
      failures++; $display("FAIL reset_flags: full=%b miss=%b bvld=%b sel=%0d want all 0",
        sif.ncwt_full, sif.bid_miss_err, sif.ebiu_b_vld, sif.ebiu_b_sel);
    end
    @(negedge clk); rstb = 1;
  endtask

  task automatic test_alloc();
    apply_reset();
    for (int i = 0; i <= N; i++) begin
      idle_inputs(); sif.ncq_aw_create_vld = 1; sif.ncq_xx_awid = 8'h20; sif.aw_needissue = 1;
      settle();
      checks++;
      if (sif.ncwt_create_en !== e_create || (i < N && sif.ncwt_create_en !== (N'(1) << i))) begin
        failures++; $display("FAIL alloc_%0d: got %h want %h", i, sif.ncwt_create_en, e_create);
      end
      checks++;
      if (sif.ncwt_full !== (i == N)) begin
        failures++; $display("FAIL alloc_full_%0d: got %b want %b", i, sif.ncwt_full, i == N);
      end
      tick();
    end
  endtask

  task automatic test_bus_order();
    logic [7:0] bids [4] = '{8'h20, 8'h20, 8'h20, 8'h55};
    logic [N-1:0] want [4] = '{8'h01, 8'h02, 8'h04, 8'h00};
    apply_reset();
    for (int i = 0; i < 3; i++) do_create(8'h20, 1);
    for (int i = 0; i < 4; i++) begin
      idle_inputs(); sif.bfifo_pop_vld = 1; sif.bfifo_pop_bid = bids[i];
      settle();
      checks++;
      if (sif.ncwt_bus_bresp_updt_en !== want[i] || sif.ncwt_bus_bresp_updt_en !== e_bus
          || sif.bid_miss_err !== (i == 3)) begin
        failures++; $display("FAIL bus_order_%0d: updt=%h miss=%b want updt=%h miss=%b",
          i, sif.ncwt_bus_bresp_updt_en, sif.bid_miss_err, want[i], i == 3);
      end
      tick();
    end
  endtask

  task automatic test_wdata_order();
    logic [N-1:0] want [3] = '{8'h01, 8'h04, 8'h02};
    apply_reset();
    for (int i = 0; i < 3; i++) do_create(8'h30, 1);
    m_vld[1] = 0;
    do_create(8'h31, 1);
    for (int i = 0; i < 3; i++) begin
      idle_inputs(); sif.ncq_wdata_done = 1;
      settle();
      checks++;
      if (sif.ncwt_wdata_create_en !== want[i] || sif.ncwt_wdata_create_en !== e_wd) begin
        failures++; $display("FAIL wdata_order_%0d: got %h want %h", i, sif.ncwt_wdata_create_en, want[i]);
      end
      tick();
    end
    idle_inputs(); sif.ncq_wdata_done = 1;
    settle();
    checks++;
    if (sif.ncwt_wdata_create_en !== '0) begin
      failures++; $display("FAIL wdata_none: got %h want 0", sif.ncwt_wdata_create_en);
    end
    tick();
  endtask

  task automatic test_excl();
    apply_reset();
    do_create(8'h1E, 0);
    do_create(8'h1E, 1);
    for (int i = 0; i < 2; i++) begin
      idle_inputs(); sif.bfifo_pop_vld = 1; sif.bfifo_pop_bid = 8'h1E;
      settle();
      checks++;
      if (sif.ncwt_bus_bresp_updt_en !== (i == 0 ? 8'h02 : 8'h00) || sif.bid_miss_err !== (i == 1)) begin
        failures++; $display("FAIL excl_%0d: updt=%h miss=%b want updt=%h miss=%b", i,
          sif.ncwt_bus_bresp_updt_en, sif.bid_miss_err, (i == 0 ? 8'h02 : 8'h00), i == 1);
      end
      tick();
    end
  endtask

  task automatic test_rr();
    int want [4] = '{0, 2, 5, 0};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      idle_inputs(); m_bvalid = 8'h25;
      settle();
      checks++;
      if (sif.ebiu_b_vld !== 1'b1 || sif.ebiu_b_sel !== 3'd0 || sif.ncwt_bresp_accept_en !== '0) begin
        failures++; $display("FAIL rr_hold_%0d: vld=%b sel=%0d acc=%h want 1 0 00", i,
          sif.ebiu_b_vld, sif.ebiu_b_sel, sif.ncwt_bresp_accept_en);
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      idle_inputs(); sif.piu_b_ready = 1; m_bvalid = 8'h25;
      settle();
      checks++;
      if (sif.ebiu_b_sel !== 3'(want[i]) || sif.ncwt_bresp_accept_en !== (N'(1) << want[i])
          || sif.ncwt_bresp_accept_en !== e_acc) begin
        failures++; $display("FAIL rr_accept_%0d: sel=%0d acc=%h want sel=%0d", i,
          sif.ebiu_b_sel, sif.ncwt_bresp_accept_en, want[i]);
      end
      tick();
    end
  endtask

  task automatic test_same_cycle();
    apply_reset();
    do_create(8'h20, 1); do_create(8'h21, 1); do_create(8'h22, 1);
    idle_inputs();
    sif.ncq_aw_create_vld = 1; sif.ncq_xx_awid = 8'h23; sif.aw_needissue = 1;
    sif.ncq_wdata_done = 1; sif.bfifo_pop_vld = 1; sif.bfifo_pop_bid = 8'h21;
    sif.piu_b_ready = 1; m_bvalid = 8'h04;
    settle();
    checks++;
    if (sif.ncwt_create_en !== 8'h08 || sif.ncwt_wdata_create_en !== 8'h01
        || sif.ncwt_bus_bresp_updt_en !== 8'h02 || sif.ncwt_bresp_accept_en !== 8'h04) begin
      failures++; $display("FAIL same_cycle: cr=%h wd=%h bus=%h acc=%h want 08 01 02 04",
        sif.ncwt_create_en, sif.ncwt_wdata_create_en, sif.ncwt_bus_bresp_updt_en, sif.ncwt_bresp_accept_en);
    end
    tick();
    // Mid-cycle asynchronous reset with live traffic: outputs drop at once.
    idle_inputs(); sif.ncq_aw_create_vld = 1; sif.ncq_wdata_done = 1; m_bvalid = 8'h08;
    sif.ncwt_bvalid = m_bvalid; sif.ncwt_vld = m_vld;
    rstb = 0; idle_inputs(); model_clear();
    #1;
    checks++;
    if ({sif.ncwt_create_en, sif.ncwt_wdata_create_en, sif.ncwt_bus_bresp_updt_en, sif.ncwt_bresp_accept_en,
         sif.ncwt_full, sif.bid_miss_err, sif.ebiu_b_vld, sif.ebiu_b_sel} !== '0) begin
      failures++; $display("FAIL async_reset_outputs: cr=%h wd=%h bus=%h acc=%h full=%b miss=%b bvld=%b sel=%0d want all 0",
        sif.ncwt_create_en, sif.ncwt_wdata_create_en, sif.ncwt_bus_bresp_updt_en, sif.ncwt_bresp_accept_en,
        sif.ncwt_full, sif.bid_miss_err, sif.ebiu_b_vld, sif.ebiu_b_sel);
    end
    #1; rstb = 1;
    sif.ncq_aw_create_vld = 1; sif.ncq_xx_awid = 8'h40; sif.aw_needissue = 1;
    sif.ncq_wdata_done = 1; sif.bfifo_pop_vld = 1; sif.bfifo_pop_bid = 8'h22;
    settle();
    checks++;
    if (sif.ncwt_create_en !== 8'h01 || sif.ncwt_wdata_create_en !== '0
        || sif.ncwt_bus_bresp_updt_en !== '0 || sif.bid_miss_err !== 1'b1) begin
      failures++; $display("FAIL async_reset_state: cr=%h wd=%h bus=%h miss=%b want 01 00 00 1",
        sif.ncwt_create_en, sif.ncwt_wdata_create_en, sif.ncwt_bus_bresp_updt_en, sif.bid_miss_err);
    end
    tick();
  endtask

  task automatic test_random();
    logic [7:0] ids [5] = '{8'h20, 8'h21, 8'h1E, 8'h3E, 8'h55};
    int f, errs;
    apply_reset();
    errs = 0;
    for (int c = 0; c < 500; c++) begin
      idle_inputs();
      sif.ncq_aw_create_vld = 1'($urandom_range(0, 1));
      sif.ncq_xx_awid = ids[$urandom_range(0, 3)];
      sif.aw_needissue = 1'($urandom_range(0, 1));
      sif.ncq_wdata_done = 1'($urandom_range(0, 1));
      sif.bfifo_pop_vld = 1'($urandom_range(0, 1));
      sif.bfifo_pop_bid = ids[$urandom_range(0, 4)];
      sif.piu_b_ready = 1'($urandom_range(0, 1));
      m_bvalid = (m_bvalid | (N'($urandom) & N'($urandom))) & m_vld;
      if ($urandom_range(0, 7) == 0) m_bvalid = m_bvalid & N'($urandom);
      f = $urandom_range(0, N - 1);
      if ($urandom_range(0, 2) == 0 && m_vld[f] && !m_bvalid[f] && !in_q(q_wd, f) && !in_q(q_bus, f))
        m_vld[f] = 0;
      settle();
      checks++;
      if (sif.ncwt_create_en !== e_create || sif.ncwt_full !== e_full) begin
        failures++; errs++;
        if (errs < 10) $display("FAIL rand_alloc c=%0d: cr=%h full=%b want %h %b", c, sif.ncwt_create_en, sif.ncwt_full, e_create, e_full);
      end
      checks++;
      if (sif.ncwt_wdata_create_en !== e_wd) begin
        failures++; errs++;
        if (errs < 10) $display("FAIL rand_wdata c=%0d: got %h want %h", c, sif.ncwt_wdata_create_en, e_wd);
      end
      checks++;
      if (sif.ncwt_bus_bresp_updt_en !== e_bus || sif.bid_miss_err !== e_miss) begin
        failures++; errs++;
        if (errs < 10) $display("FAIL rand_bus c=%0d: updt=%h miss=%b want %h %b", c, sif.ncwt_bus_bresp_updt_en, sif.bid_miss_err, e_bus, e_miss);
      end
      checks++;
      if (sif.ebiu_b_vld !== e_bvld || sif.ebiu_b_sel !== 3'(e_sel) || sif.ncwt_bresp_accept_en !== e_acc) begin
        failures++; errs++;
        if (errs < 10) $display("FAIL rand_ret c=%0d: vld=%b sel=%0d acc=%h want %b %0d %h", c,
          sif.ebiu_b_vld, sif.ebiu_b_sel, sif.ncwt_bresp_accept_en, e_bvld, e_sel, e_acc);
      end
      tick();
    end
  endtask

  initial begin
    idle_inputs(); model_clear();
    @(negedge clk);
    test_reset();
    test_alloc();
    test_bus_order();
    test_wdata_order();
    test_excl();
    test_rr();
    test_same_cycle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
